// File: rtl/servo_axi_multi.sv
// servo_axi_multi: AXI4-Lite servo PWM peripheral with N_CH channels sharing
// one period counter.
//
// Registers (word addresses):
//   0x00 CTRL   [0] enable, [1] irq_en
//   0x04 PERIOD [CNT_W-1:0] period length in ticks
//   0x08 CH_EN  [N_CH-1:0] per-channel output enable (takes effect at once)
//   0x0C STATUS [0] period_done, sticky, write-1-to-clear
//   0x10+4k PULSE[k] [CNT_W-1:0] pulse width in ticks (pending value)
//   0x10+4*N_CH RAMP [CNT_W-1:0] (only when SERVO_AXI_RAMP_EN is defined)
//
// Optional feature macro: SERVO_AXI_RAMP_EN. When defined, each shadow load
// moves PULSE_sh[k] toward PULSE[k] by at most RAMP ticks (RAMP=0 jumps).
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   s_axi_aw*/w*/b*     AXI4-Lite write address/data/response channels
//   s_axi_ar*/r*        AXI4-Lite read address/data channels
//   pwm_out[N_CH]       registered servo pulse outputs
//   period_irq          level interrupt = STATUS[0] & CTRL[1]
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. awready/wready are issued together only when both address and
// data are valid and no write response is pending; arready is issued only
// when no read data is pending. bvalid/rvalid then hold until bready/rready.
module servo_axi_multi #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 20,
    parameter int TICK_DIV = 100,
    parameter int ADDR_W   = 7
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_irq
);

`ifdef SERVO_AXI_RAMP_EN
    localparam int RAMP_WORDS = 1;
`else
    localparam int RAMP_WORDS = 0;
`endif
    localparam int N_WORDS = 4 + N_CH + RAMP_WORDS;
    localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]       ctrl;
    logic [CNT_W-1:0] period;
    logic [N_CH-1:0]  ch_en;
    logic             status;
    logic [CNT_W-1:0] pulse    [N_CH];
    logic [CNT_W-1:0] pulse_sh [N_CH];
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] presc;
    logic             started;
`ifdef SERVO_AXI_RAMP_EN
    logic [CNT_W-1:0] ramp;
`endif

    logic        wr_hs, rd_hs, wr_mapped, rd_mapped, tick, load;
    int          wr_idx, rd_idx;
    logic [31:0] wmask, wr_old, wr_val, rd_word;
    logic        unused_bits;

    // Register file read view; unlisted bits and unmapped words read as 0.
    function automatic logic [31:0] reg_word(input int idx);
        logic [31:0] w;
        w = '0;
        case (idx)
            0:       w[1:0]       = ctrl;
            1:       w[CNT_W-1:0] = period;
            2:       w[N_CH-1:0]  = ch_en;
            3:       w[0]         = status;
            default: ;
        endcase
        for (int k = 0; k < N_CH; k++)
            if (idx == 4 + k) w[CNT_W-1:0] = pulse[k];
`ifdef SERVO_AXI_RAMP_EN
        if (idx == 4 + N_CH) w[CNT_W-1:0] = ramp;
`endif
        return w;
    endfunction

`ifdef SERVO_AXI_RAMP_EN
    // Step cur toward tgt by at most step; step=0 means jump straight to tgt.
    function automatic logic [CNT_W-1:0] ramp_step(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt,
                                                   input logic [CNT_W-1:0] step);
        if (step == '0 || tgt == cur) return tgt;
        if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
        return (cur - tgt > step) ? cur - step : tgt;
    endfunction
`endif

    always_comb begin
        wr_hs     = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~ARESET;
        rd_hs     = s_axi_arvalid & ~s_axi_rvalid & ~ARESET;
        wr_idx    = 32'(s_axi_awaddr[ADDR_W-1:2]);
        rd_idx    = 32'(s_axi_araddr[ADDR_W-1:2]);
        wr_mapped = (wr_idx < N_WORDS);
        rd_mapped = (rd_idx < N_WORDS);
        for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{s_axi_wstrb[b]}};
        // Byte-strobe merge against the current register contents.
        wr_old  = reg_word(wr_idx);
        wr_val  = (wr_old & ~wmask) | (s_axi_wdata & wmask);
        rd_word = reg_word(rd_idx);
    end

    assign s_axi_awready = wr_hs;
    assign s_axi_wready  = wr_hs;
    assign s_axi_arready = rd_hs;
    assign period_irq    = status & ctrl[1];
    assign unused_bits   = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0], wr_val};

    // Tick at the last prescaler count. A shadow load happens at the period
    // wrap, on the first tick after enable, and on every tick while the
    // shadow period is 0.
    always_comb begin
        tick = ctrl[0] && (presc == PRE_MAX);
        load = tick && (!started || period_sh == '0 ||
                        cnt >= period_sh - CNT_W'(1));
    end

    // AXI channels and software-visible registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl         <= '0;
            period       <= '0;
            ch_en        <= '0;
            status       <= 1'b0;
            for (int k = 0; k < N_CH; k++) pulse[k] <= '0;
`ifdef SERVO_AXI_RAMP_EN
            ramp         <= '0;
`endif
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else begin
            if (wr_hs) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (wr_hs && wr_mapped) begin
                case (wr_idx)
                    0:       ctrl   <= wr_val[1:0];
                    1:       period <= wr_val[CNT_W-1:0];
                    2:       ch_en  <= wr_val[N_CH-1:0];
                    default: ;
                endcase
                for (int k = 0; k < N_CH; k++)
                    if (wr_idx == 4 + k) pulse[k] <= wr_val[CNT_W-1:0];
`ifdef SERVO_AXI_RAMP_EN
                if (wr_idx == 4 + N_CH) ramp <= wr_val[CNT_W-1:0];
`endif
            end

            // A period event in the same cycle as a clear keeps the flag set.
            if (load)
                status <= 1'b1;
            else if (wr_hs && wr_idx == 3 && s_axi_wstrb[0] && s_axi_wdata[0])
                status <= 1'b0;

            if (rd_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
                s_axi_rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Prescaler, period counter, shadows and pulse outputs.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            presc     <= '0;
            cnt       <= '0;
            started   <= 1'b0;
            period_sh <= '0;
            for (int k = 0; k < N_CH; k++) pulse_sh[k] <= '0;
            pwm_out   <= '0;
        end else begin
            if (!ctrl[0]) begin
                presc   <= '0;
                cnt     <= '0;
                started <= 1'b0;
            end else begin
                presc <= tick ? '0 : presc + PRE_W'(1);
                if (tick) begin
                    started <= 1'b1;
                    cnt     <= load ? '0 : cnt + CNT_W'(1);
                end
            end

            if (load) begin
                period_sh <= period;
                for (int k = 0; k < N_CH; k++) begin
`ifdef SERVO_AXI_RAMP_EN
                    pulse_sh[k] <= ramp_step(pulse_sh[k], pulse[k], ramp);
`else
                    pulse_sh[k] <= pulse[k];
`endif
                end
            end

            // A zero shadow period forces every output low.
            for (int k = 0; k < N_CH; k++)
                pwm_out[k] <= ctrl[0] & ch_en[k] & (period_sh != '0) &
                              (cnt < pulse_sh[k]);
        end
    end

endmodule
